// File: rtl/pixel_streamer_pkg.sv
// Shared types and widths for the pixel streamer: FSM state encoding and
// pixel/coordinate/channel widths.
package pixel_streamer_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned CH_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y/channel counters with wrap flags; hold freezes the scan
// position while a step is requested.
module raster_counter
  import pixel_streamer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic            next_ch,
  input  logic            adv,
  input  logic            hold,
  input  logic [X_W-1:0]  x_max,
  input  logic [Y_W-1:0]  y_max,
  input  logic [CH_W-1:0] ch_max,
  output logic [X_W-1:0]  x,
  output logic [Y_W-1:0]  y,
  output logic            x_wrap_c,
  output logic            y_wrap_c,
  output logic            ch_wrap_c
);

  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [CH_W-1:0] ch_q, ch_d;

  assign x_wrap_c  = (x_q == x_max);
  assign y_wrap_c  = (y_q == y_max);
  assign ch_wrap_c = (ch_q == ch_max);
  assign x         = x_q;
  assign y         = y_q;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    ch_d = ch_q;
    if (init) begin
      x_d  = '0;
      y_d  = '0;
      ch_d = '0;
    end else if (next_ch) begin
      x_d  = '0;
      y_d  = '0;
      ch_d = ch_q + CH_W'(1);
    end else if (adv && !hold) begin
      if (x_wrap_c) begin
        x_d = '0;
        y_d = y_wrap_c ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      ch_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      ch_q <= ch_d;
    end
  end

endmodule

// File: rtl/pixel_streamer.sv
// Streams a multi-channel frame out of frame memory in raster order.
// PIXEL_STREAMER_PAD_EN adds a one-pixel zero border around every channel.
module pixel_streamer
  import pixel_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MAX_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  input  logic [3:0]        num_ch,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              clear,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [7:0]        w_q, w_d, h_q, h_d;
  logic [CH_W-1:0]   nch_q, nch_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pv_q, pv_d;
  logic [X_W-1:0]    px_q, px_d;
  logic [Y_W-1:0]    py_q, py_d;
  logic              clear_q, clear_d, busy_q, busy_d, done_q, done_d;

  logic [X_W-1:0]    cnt_x, x_max;
  logic [Y_W-1:0]    cnt_y, y_max;
  logic              x_wrap, y_wrap, ch_wrap;
  logic              cnt_init, cnt_next_ch, scan_en, issue;

`ifdef PIXEL_STREAMER_PAD_EN
  logic pb_q, pb_d, border;
  assign x_max     = X_W'(w_q) + X_W'(1);
  assign y_max     = Y_W'(h_q) + Y_W'(1);
  assign border    = (cnt_x == '0) || (cnt_x == x_max) || (cnt_y == '0) || (cnt_y == y_max);
  assign mem_rd_en = issue && !border;
  assign pixel_out = (pv_q && !pb_q) ? mem_rdata : '0;
`else
  assign x_max     = X_W'(w_q) - X_W'(1);
  assign y_max     = Y_W'(h_q) - Y_W'(1);
  assign mem_rd_en = issue;
  assign pixel_out = pv_q ? mem_rdata : '0;
`endif

  assign scan_en     = (state_q == ST_STREAM);
  assign issue       = scan_en && !stall;
  assign mem_addr    = ptr_q;
  assign pixel_valid = pv_q;
  assign x           = px_q;
  assign y           = py_q;
  assign clear       = clear_q;
  assign busy        = busy_q;
  assign done        = done_q;

  raster_counter u_raster (
    .clk       (clk),
    .reset     (reset),
    .init      (cnt_init),
    .next_ch   (cnt_next_ch),
    .adv       (scan_en),
    .hold      (stall),
    .x_max     (x_max),
    .y_max     (y_max),
    .ch_max    (nch_q - CH_W'(1)),
    .x         (cnt_x),
    .y         (cnt_y),
    .x_wrap_c  (x_wrap),
    .y_wrap_c  (y_wrap),
    .ch_wrap_c (ch_wrap)
  );

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    nch_d       = nch_q;
    ptr_d       = ptr_q;
    cnt_init    = 1'b0;
    cnt_next_ch = 1'b0;
    if (mem_rd_en) ptr_d = ptr_q + ADDR_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d      = (32'(img_width) > MAX_W) ? 8'(MAX_W) : img_width;
          h_d      = img_height;
          nch_d    = (num_ch == '0) ? CH_W'(1) : num_ch;
          ptr_d    = base_addr;
          cnt_init = 1'b1;
          state_d  = (img_width == '0 || img_height == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR:  state_d = ST_STREAM;
      ST_STREAM: if (issue && x_wrap && y_wrap) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ch_wrap) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_CLEAR;
          cnt_next_ch = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Pixel-side pipeline: one stage behind the issued scan position.
    pv_d    = issue;
    px_d    = cnt_x;
    py_d    = cnt_y;
    clear_d = (state_d == ST_CLEAR);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
`ifdef PIXEL_STREAMER_PAD_EN
    pb_d    = border;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      nch_q   <= '0;
      ptr_q   <= '0;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PIXEL_STREAMER_PAD_EN
      pb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      nch_q   <= nch_d;
      ptr_q   <= ptr_d;
      pv_q    <= pv_d;
      px_q    <= px_d;
      py_q    <= py_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PIXEL_STREAMER_PAD_EN
      pb_q    <= pb_d;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: frame-memory model, per-frame
// expected read/pixel queues built from frame geometry, randomized stall.
module tb_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic [7:0]  img_width, img_height;
  logic [3:0]  num_ch;
  logic [15:0] base_addr;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata, pixel_out;
  logic        pixel_valid;
  logic [10:0] x;
  logic [9:0]  y;
  logic        clear, busy, done;

  typedef struct packed {
    logic [7:0]  pix;
    logic [10:0] px;
    logic [9:0]  py;
  } pix_t;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr[$];
  pix_t        exp_pix[$];
  pix_t        e;
  int          n_tests, n_fail, clr_cnt, done_cnt, pix_cnt, exp_clr;
  int          mon_cyc, last_pv;
  logic        prev_rd;
  logic [15:0] prev_addr;

  always #5 clk = ~clk;

  pixel_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .img_width   (img_width),
    .img_height  (img_height),
    .num_ch      (num_ch),
    .base_addr   (base_addr),
    .stall       (stall),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .clear       (clear),
    .busy        (busy),
    .done        (done)
  );

  // Synchronous-read frame memory; junk data when no read was issued.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected reads and pixels of one frame, straight from the geometry.
  task automatic build(input int w_in, input int h_in, input int nch_in, input logic [15:0] base);
    int w, h, nc, off, pw, ph;
    logic [15:0] a;
    pix_t p;
    w  = (w_in > 128) ? 128 : w_in;
    h  = h_in;
    nc = (nch_in == 0) ? 1 : nch_in;
`ifdef PIXEL_STREAMER_PAD_EN
    off = 1;
`else
    off = 0;
`endif
    pw = w + 2 * off;
    ph = h + 2 * off;
    exp_addr.delete();
    exp_pix.delete();
    exp_clr = (w == 0 || h == 0) ? 0 : nc;
    if (w == 0 || h == 0) return;
    for (int c = 0; c < nc; c++)
      for (int py = 0; py < ph; py++)
        for (int px = 0; px < pw; px++) begin
          p.px = 11'(px);
          p.py = 10'(py);
          if (px < off || py < off || px >= w + off || py >= h + off) begin
            p.pix = 8'h00;
          end else begin
            a = 16'(int'(base) + c * w * h + (py - off) * w + (px - off));
            exp_addr.push_back(a);
            p.pix = mem[a];
          end
          exp_pix.push_back(p);
        end
  endtask

  // Cycle monitor: every read and every pixel is scored against the queues.
  always @(negedge clk) begin
    mon_cyc++;
    if (!reset) begin
      if (prev_rd) check("latency", 32'(pixel_valid), 32'd1);
`ifndef PIXEL_STREAMER_PAD_EN
      if (pixel_valid) check("valid_wo_read", 32'(prev_rd), 32'd1);
`endif
      if (mem_rd_en) begin
        check("rd_in_stall", 32'(stall), 32'd0);
        check("rd_pending", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0) check("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
      if (pixel_valid) begin
        pix_cnt++;
        last_pv = mon_cyc;
        check("pix_pending", 32'(exp_pix.size() != 0), 32'd1);
        if (exp_pix.size() != 0) begin
          e = exp_pix.pop_front();
          check("pix_val", 32'(pixel_out), 32'(e.pix));
          check("pix_x", 32'(x), 32'(e.px));
          check("pix_y", 32'(y), 32'(e.py));
        end
      end
      if (clear) begin
        clr_cnt++;
        check("clear_pv", 32'(pixel_valid), 32'd0);
      end
      if (done) begin
        done_cnt++;
        check("done_pending", 32'(exp_pix.size()), 32'd0);
        if (pix_cnt > 0) check("done_gap", 32'(mon_cyc - last_pv), 32'd1);
      end
    end
    prev_rd   = mem_rd_en && !reset;
    prev_addr = mem_addr;
  end

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_pix"}, 32'(pixel_out), 32'd0);
    check({tag, "_valid"}, 32'(pixel_valid), 32'd0);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_clear"}, 32'(clear), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic pulse_start(input int w, input int h, input int nch, input logic [15:0] base);
    clr_cnt  = 0;
    done_cnt = 0;
    pix_cnt  = 0;
    @(posedge clk); #1;
    img_width  = 8'(w);
    img_height = 8'(h);
    num_ch     = 4'(nch);
    base_addr  = base;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_run", 32'(busy), 32'd1);
  endtask

  // mode 0: no stall, 1: random stall, 2: 3-cycle stall right after the x=1 read.
  task automatic run_frame(input int w, input int h, input int nch, input logic [15:0] base,
                           input int mode, input bit restart);
    int cyc, hold;
    bit fired;
    cyc   = 0;
    hold  = 0;
    fired = 1'b0;
    build(w, h, nch, base);
    pulse_start(w, h, nch, base);
    while (done_cnt == 0 && cyc < 4000) begin
      start = restart && (cyc == 4);
      if (start) begin
        img_width  = 8'd0;
        img_height = 8'd0;
        num_ch     = 4'd7;
        base_addr  = 16'hFFF0;
      end
      if (mode == 2 && !fired && prev_rd && prev_addr == base + 16'd1) begin
        fired = 1'b1;
        hold  = 3;
      end
      if (hold > 0) begin
        stall = 1'b1;
        hold--;
      end else begin
        stall = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("timeout", 32'(cyc < 4000), 32'd1);
    check("done_count", 32'(done_cnt), 32'd1);
    check("clear_count", 32'(clr_cnt), 32'(exp_clr));
    check("reads_left", 32'(exp_addr.size()), 32'd0);
    check("pix_left", 32'(exp_pix.size()), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    if (mode == 2) check("stall_fired", 32'(fired), 32'd1);
  endtask

  task automatic reset_mid_frame();
    int cyc;
    cyc = 0;
    build(4, 3, 1, 16'h0300);
    pulse_start(4, 3, 1, 16'h0300);
    while (pix_cnt < 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reach_pix5", 32'(cyc < 200), 32'd1);
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");
    reset = 1'b0;
    exp_addr.delete();
    exp_pix.delete();
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    mon_cyc    = 0;
    last_pv    = 0;
    reset      = 1'b1;
    start      = 1'b0;
    stall      = 1'b0;
    img_width  = 8'd0;
    img_height = 8'd0;
    num_ch     = 4'd0;
    base_addr  = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;

    run_frame(4, 3, 1, 16'h0100, 0, 1'b0);
    run_frame(4, 2, 3, 16'h0000, 0, 1'b0);
    run_frame(4, 3, 1, 16'h0200, 2, 1'b0);
    run_frame(0, 5, 2, 16'h0400, 0, 1'b0);
    run_frame(3, 0, 1, 16'h0400, 0, 1'b0);
    run_frame(5, 4, 2, 16'h0500, 0, 1'b1);
    run_frame(3, 2, 0, 16'h0600, 0, 1'b0);
    run_frame(2, 2, 1, 16'h0040, 0, 1'b0);
    reset_mid_frame();
    run_frame(4, 3, 1, 16'h0300, 0, 1'b0);
    run_frame(3, 2, 2, 16'hFFFA, 1, 1'b0);
    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(1, 8), $urandom_range(1, 6), $urandom_range(0, 3),
                16'($urandom), 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, frame-memory address width.
REQ-002 The block SHALL have parameter MAX_W, default 128, maximum image width in pixels.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle launch pulse, sampled only in IDLE.
REQ-006 img_width  input  8  pixels per row, at most MAX_W; latched at start.
REQ-007 img_height  input  8  rows per channel; latched at start.
REQ-008 num_ch  input  4  channel count, latched at start; 0 SHALL be treated as 1.
REQ-009 base_addr  input  ADDR_W  address of channel 0, pixel (0,0); latched at start.
REQ-010 stall  input  1  downstream hold; while high, no new read SHALL be issued.
REQ-011 mem_rd_en  output  1  frame-memory read strobe.
REQ-012 mem_addr  output  ADDR_W  frame-memory read address.
REQ-013 mem_rdata  input  8  read data, valid exactly one cycle after mem_rd_en.
REQ-014 pixel_out  output  8  streamed pixel.
REQ-015 pixel_valid  output  1  pixel_out, x and y are valid this cycle.
REQ-016 x  output  11  column of pixel_out.
REQ-017 y  output  10  row of pixel_out.
REQ-018 clear  output  1  one-cycle flush pulse to the window buffer before each channel.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse after the last pixel of the last channel.

Function
REQ-021 The FSM SHALL have the states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-022 Transitions: IDLE->CLEAR on start; CLEAR->STREAM after 1 cycle; STREAM->DRAIN after the last read of a channel; DRAIN->CLEAR if channels remain, else DRAIN->DONE; DONE->IDLE after 1 cycle.
REQ-023 clear SHALL be high for exactly the one CLEAR cycle; pixel_valid SHALL be low during that cycle.
REQ-024 In STREAM with stall low, the block SHALL assert mem_rd_en once per cycle in raster order: x from 0 to W-1, then x wraps to 0 and y increments.
REQ-025 Read addresses SHALL be base_addr + ch*W*H + y*W + x, produced by a running pointer (no multiplier), wrapping modulo 2^ADDR_W.
REQ-026 pixel_valid, pixel_out = mem_rdata, x and y SHALL appear exactly 1 cycle after the matching mem_rd_en; latency is fixed at 1.
REQ-027 With stall high, the scan position SHALL hold and mem_rd_en SHALL be low; an already-issued read SHALL still produce its pixel_valid on the next cycle.
REQ-028 DRAIN SHALL last exactly 1 cycle so that the final pixel_valid precedes the next clear or the done pulse.
REQ-029 If img_width or img_height is 0 at start, the block SHALL go IDLE->DONE: no clear, no reads, done pulses once.
REQ-030 start while busy SHALL be ignored; the latched parameters SHALL NOT change mid-frame.
REQ-031 x and y SHALL be zero-extended from the internal counters.

Reset
REQ-032 Reset SHALL force IDLE and drive mem_rd_en, mem_addr, pixel_out, pixel_valid, x, y, clear, busy and done to 0, and clear all counters.
REQ-033 Reset asserted mid-frame SHALL abort without a done pulse; any outstanding read data SHALL be discarded.

Configuration
REQ-034 Macro PIXEL_STREAMER_PAD_EN: when defined, each channel SHALL be scanned as (W+2)x(H+2), with a zero border.
REQ-035 With the macro defined, a border position SHALL emit pixel_out=0 with pixel_valid high and mem_rd_en low, with the same 1-cycle timing as an interior pixel; x and y are padded coordinates; an interior pixel at padded (x,y) SHALL read source pixel (x-1,y-1).
REQ-036 With the macro not defined, no padding logic SHALL exist and the scan SHALL be WxH.

Structure
REQ-037 The shared package SHALL hold the FSM state encoding, PIX_W=8, X_W=11 and Y_W=10.
REQ-038 The block SHALL instantiate one sub-module, raster_counter, providing x/y/channel counters with wrap flags and a hold input.

Verification
REQ-039 Reset, then start with W=4, H=3, ch=1, base=0x0100: clear high 1 cycle; 12 reads at 0x0100-0x010B; pixel_valid 1 cycle after each read; x/y follow 0..3 / 0..2; done 1 cycle after the final pixel.
REQ-040 W=4, H=2, ch=3, base=0: three clear pulses; channel 2 starts at address 16; 24 pixels total; exactly one done pulse.
REQ-041 Hold stall high for 3 cycles mid-row at x=2: no reads for those cycles; pixel (1,y) still emitted; scan resumes at x=2 with no gap or duplicate.
REQ-042 start with W=0: done pulses with no clear and no reads; a second start while busy during a normal frame is ignored.
REQ-043 Assert reset at pixel 5 of a 4x3 frame: all outputs 0 and no done pulse; a later start runs a full clean frame.
REQ-044 With PIXEL_STREAMER_PAD_EN, W=2, H=2: 16 pixels; the 12 border pixels are 0 with no read; the 4 interior pixels read addresses base..base+3 at padded (1,1), (2,1), (1,2), (2,2).
